hlamgcd: RTL and testbench

HLAMGCD -- requirements
Module: hlamgcd

---
 rtl/hlamgcd.sv | 80 ++++++++
 tb/tb_hlamgcd.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hlamgcd.sv
// hlamgcd: iterative GCD by repeated subtraction, one step per clock.
// Ports: clk, reset (sync, active-low), start, a, b -> done, result.
module hlamgcd #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic             x_lt_y;
  logic [WIDTH-1:0] x_minus_y;
  logic [WIDTH-1:0] y_minus_x;

  // Only the difference selected by x_lt_y is ever stored, so the
  // smaller operand is always taken from the larger one.
  assign x_lt_y    = (x_q < y_q);
  assign x_minus_y = x_q - y_q;
  assign y_minus_x = y_q - x_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          // result_q is left alone so it holds until the next finish.
          if (start) begin
            x_q     <= a;
            y_q     <= b;
            done_q  <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (x_q == '0) begin
            result_q <= y_q;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (y_q == '0 || x_q == y_q) begin
            result_q <= x_q;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (x_lt_y) begin
            y_q <= y_minus_x;
          end else begin
            x_q <= x_minus_y;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_hlamgcd.sv
// tb_hlamgcd: scoreboard bench for hlamgcd.
// Driver pushes expected (result, done edge); monitor pops on done rise.
module tb_hlamgcd;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         done;
  logic [W-1:0] result;

  hlamgcd #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .done   (done),
    .result (result)
  );

  typedef struct {
    int res;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic start_s  = 1'b0;
  logic rst_s    = 1'b0;
  logic done_prev = 1'b0;
  int   held     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  // Reference GCD by Euclid's division algorithm.
  function automatic int ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Subtraction steps to reach equality = sum of Euclid quotients - 1.
  function automatic int ref_steps(input int x, input int y);
    int s, t;
    if (x == 0 || y == 0) return 0;
    s = 0;
    while (y != 0) begin
      s += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    return s - 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    start_s = start;
    rst_s   = reset;
  end

  // Monitor: compares on every done rise; also watches hold and fall.
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("result", int'(result), e.res);
        chk("latency_edge", cyc, e.due);
      end
      held = int'(result);
    end else if (done && done_prev) begin
      chk("result_hold", int'(result), held);
    end
    if (!done && done_prev && rst_s)
      chk("done_fall_on_start", int'(start_s), 1);
    done_prev = done;
  end

  task automatic pulse(input int av, input int bv, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a     = W'(av);
    b     = W'(bv);
    @(negedge clk);
    if (push) begin
      e.res = ref_gcd(av, bv);
      e.due = cyc + ref_steps(av, bv) + 1;
      q.push_back(e);
    end
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
  endtask

  task automatic issue(input int av, input int bv);
    pulse(av, bv, 1'b1);
    wait_empty();
  endtask

  initial begin
    int av, bv;
    reset = 1'b0;
    start = 1'b1;
    a     = 8'd7;
    b     = 8'd3;
    repeat (3) @(negedge clk);
    chk("reset_done", int'(done), 0);
    chk("reset_result", int'(result), 0);
    start = 1'b0;
    reset = 1'b1;

    issue(12, 8);
    repeat (3) @(negedge clk);
    chk("hold_done", int'(done), 1);
    issue(15, 15);
    issue(1, 15);

    pulse(1, 15, 1'b1);
    repeat (4) @(negedge clk);
    pulse(6, 4, 1'b0);
    wait_empty();
    chk("ignored_start_result", int'(result), 1);

    issue(0, 9);
    issue(0, 0);
    issue(9, 0);
    issue(1, 255);
    issue(255, 1);

    for (int i = 1; i <= 15; i++)
      for (int j = 1; j <= 15; j++)
        issue(i, j);

    for (int n = 0; n < 150; n++) begin
      av = $urandom_range(0, 255);
      bv = $urandom_range(0, 255);
      issue(av, bv);
    end

    pulse(1, 200, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    reset = 1'b1;
    repeat (250) @(negedge clk);
    chk("abort_no_done", int'(done), 0);
    issue(9, 6);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
